control_arranque: RTL and testbench

CONTROL_ARRANQUE -- requirements
Module: control_arranque

---
 rtl/control_arranque.sv | 211 +++++++++++++++++++++
 tb/tb_control_arranque.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_arranque.sv
// -----------------------------------------------------------------------------
// control_arranque
//
// Start-request controller for the vehicle start sequence. It conditions a raw
// start push-button and a raw gas/electric mode switch, then runs a four-state
// controller that grants a start request only with key present and brake
// pressed. Repeated presses without the brake lead to a lockout state, which is
// cleared only by removing the key or by reset.
//
// Parameters
//   DEBOUNCE   : consecutive stable samples needed to accept a button change (1..15)
//   MAX_FALLOS : failed start attempts (press without brake) that cause lockout (1..15)
//
// Ports
//   CLK       in  1  system clock, every register updates on its rising edge
//   REINICIO  in  1  synchronous active-high reset
//   BOTON     in  1  raw asynchronous start push-button, 1 = pressed
//   SELECTOR  in  1  raw asynchronous mode switch, 1 = gas, 0 = electric
//   LLAVE     in  1  key present, already synchronous to CLK
//   FRENO     in  1  brake pressed, already synchronous to CLK
//   ARRANQUE  out 1  start request level to the downstream vehicle FSM
//   MODO      out 1  mode latched at the successful start, 1 = gas
//   LISTO     out 1  ready to accept a start press
//   ERROR     out 1  lockout after too many failed attempts
// -----------------------------------------------------------------------------
module control_arranque #(
  parameter int DEBOUNCE   = 4,
  parameter int MAX_FALLOS = 3
) (
  input  logic CLK,
  input  logic REINICIO,
  input  logic BOTON,
  input  logic SELECTOR,
  input  logic LLAVE,
  input  logic FRENO,
  output logic ARRANQUE,
  output logic MODO,
  output logic LISTO,
  output logic ERROR
);

  // The debounce counter reaches DEB_LAST_C on the DEBOUNCE-th mismatching
  // sample; that sample is the one that updates the debounced value.
  localparam logic [3:0] DEB_LAST_C   = 4'(DEBOUNCE - 1);
  localparam logic [3:0] MAX_FALLOS_C = 4'(MAX_FALLOS);

  typedef enum logic [1:0] {
    APAGADO   = 2'b00,
    ESPERA    = 2'b01,
    ARRANCADO = 2'b10,
    BLOQUEO   = 2'b11
  } estado_t;

  // Synchronizers
  logic [1:0] boton_sync_r;
  logic [1:0] selector_sync_r;
  logic       boton_sync_s;
  logic       selector_sync_s;

  // Debounce
  logic       boton_deb_r;
  logic       boton_deb_prev_r;
  logic [3:0] estable_cnt_r;
  logic       pulsacion_s;

  // Controller
  estado_t    estado_r;
  estado_t    estado_nxt_s;
  logic [3:0] fallos_r;
  logic [3:0] fallos_nxt_s;
  logic [3:0] fallos_inc_s;
  logic       modo_r;
  logic       modo_nxt_s;

  // Registered outputs
  logic       arranque_r;
  logic       listo_r;
  logic       error_r;

  assign boton_sync_s    = boton_sync_r[1];
  assign selector_sync_s = selector_sync_r[1];

  // One-cycle press event on a debounced rising edge of the button.
  assign pulsacion_s  = boton_deb_r & ~boton_deb_prev_r;
  assign fallos_inc_s = fallos_r + 4'd1;

  // Two-stage synchronizers for the asynchronous button and mode switch.
  always_ff @(posedge CLK) begin
    if (REINICIO) begin
      boton_sync_r    <= 2'b00;
      selector_sync_r <= 2'b00;
    end else begin
      boton_sync_r    <= {boton_sync_r[0], BOTON};
      selector_sync_r <= {selector_sync_r[0], SELECTOR};
    end
  end

  // Button debounce: accept the synchronized level after DEBOUNCE consecutive
  // samples that differ from the accepted level; a matching sample restarts it.
  always_ff @(posedge CLK) begin
    if (REINICIO) begin
      boton_deb_r      <= 1'b0;
      boton_deb_prev_r <= 1'b0;
      estable_cnt_r    <= 4'd0;
    end else begin
      boton_deb_prev_r <= boton_deb_r;
      if (boton_sync_s != boton_deb_r) begin
        if (estable_cnt_r == DEB_LAST_C) begin
          boton_deb_r   <= boton_sync_s;
          estable_cnt_r <= 4'd0;
        end else begin
          estable_cnt_r <= estable_cnt_r + 4'd1;
        end
      end else begin
        estable_cnt_r <= 4'd0;
      end
    end
  end

  // Next-state, failure count and mode latch for the start controller.
  always_comb begin
    estado_nxt_s = estado_r;
    fallos_nxt_s = fallos_r;
    modo_nxt_s   = modo_r;
    case (estado_r)
      APAGADO: begin
        // Counter and mode are held cleared while off.
        fallos_nxt_s = 4'd0;
        modo_nxt_s   = 1'b0;
        if (LLAVE) begin
          estado_nxt_s = ESPERA;
        end else begin
          estado_nxt_s = APAGADO;
        end
      end
      ESPERA: begin
        // Key removal wins over a press arriving on the same cycle.
        if (!LLAVE) begin
          estado_nxt_s = APAGADO;
          fallos_nxt_s = 4'd0;
          modo_nxt_s   = 1'b0;
        end else if (pulsacion_s) begin
          if (FRENO) begin
            estado_nxt_s = ARRANCADO;
            fallos_nxt_s = 4'd0;
            modo_nxt_s   = selector_sync_s;
          end else begin
            fallos_nxt_s = fallos_inc_s;
            if (fallos_inc_s == MAX_FALLOS_C) begin
              estado_nxt_s = BLOQUEO;
            end else begin
              estado_nxt_s = ESPERA;
            end
          end
        end else begin
          estado_nxt_s = ESPERA;
        end
      end
      ARRANCADO: begin
        // Presses and mode switch changes are ignored; mode stays latched.
        if (!LLAVE) begin
          estado_nxt_s = APAGADO;
          fallos_nxt_s = 4'd0;
          modo_nxt_s   = 1'b0;
        end else begin
          estado_nxt_s = ARRANCADO;
        end
      end
      BLOQUEO: begin
        if (!LLAVE) begin
          estado_nxt_s = APAGADO;
          fallos_nxt_s = 4'd0;
          modo_nxt_s   = 1'b0;
        end else begin
          estado_nxt_s = BLOQUEO;
        end
      end
      default: begin
        estado_nxt_s = APAGADO;
        fallos_nxt_s = 4'd0;
        modo_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, counter, mode and output registers. Outputs are decoded from the
  // next state so they change on the same edge as the state register.
  always_ff @(posedge CLK) begin
    if (REINICIO) begin
      estado_r   <= APAGADO;
      fallos_r   <= 4'd0;
      modo_r     <= 1'b0;
      arranque_r <= 1'b0;
      listo_r    <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      estado_r   <= estado_nxt_s;
      fallos_r   <= fallos_nxt_s;
      modo_r     <= modo_nxt_s;
      arranque_r <= (estado_nxt_s == ARRANCADO);
      listo_r    <= (estado_nxt_s == ESPERA);
      error_r    <= (estado_nxt_s == BLOQUEO);
    end
  end

  assign ARRANQUE = arranque_r;
  assign MODO     = modo_r;
  assign LISTO    = listo_r;
  assign ERROR    = error_r;

endmodule

// File: tb/tb_control_arranque.sv
// -----------------------------------------------------------------------------
// tb_control_arranque
//
// Directed bench for control_arranque (DEBOUNCE=4, MAX_FALLOS=3). Expected
// output vectors {ARRANQUE, MODO, LISTO, ERROR} are queued when a stimulus
// step is driven and popped and compared once the DUT has had the cycles to
// respond. The failure counter is also checked through the internal register.
// -----------------------------------------------------------------------------
module tb_control_arranque;

  logic CLK;
  logic REINICIO;
  logic BOTON;
  logic SELECTOR;
  logic LLAVE;
  logic FRENO;
  logic ARRANQUE;
  logic MODO;
  logic LISTO;
  logic ERROR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];

  control_arranque #(
    .DEBOUNCE   (4),
    .MAX_FALLOS (3)
  ) dut (
    .CLK      (CLK),
    .REINICIO (REINICIO),
    .BOTON    (BOTON),
    .SELECTOR (SELECTOR),
    .LLAVE    (LLAVE),
    .FRENO    (FRENO),
    .ARRANQUE (ARRANQUE),
    .MODO     (MODO),
    .LISTO    (LISTO),
    .ERROR    (ERROR)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic push_exp(input string tag, input logic [3:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [3:0] obs;
    obs = {ARRANQUE, MODO, LISTO, ERROR};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b expected <queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed {ARR,MODO,LISTO,ERR}=%b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  // Queue an expectation, run n edges, compare at the following negedge.
  task automatic step_chk(input int n, input string tag, input logic [3:0] exp);
    push_exp(tag, exp);
    tick(n);
    pop_check();
  endtask

  task automatic check_fallos(input string tag, input logic [3:0] exp);
    checks++;
    assert (dut.fallos_r === exp) else begin
      errors++;
      $error("FAIL %s: observed fallos=%0d expected %0d", tag, dut.fallos_r, exp);
    end
  endtask

  // Full debounced press and release.
  task automatic press();
    BOTON = 1'b1;
    tick(8);
    BOTON = 1'b0;
    tick(8);
  endtask

  initial begin
    REINICIO = 1'b1;
    BOTON    = 1'b0;
    SELECTOR = 1'b0;
    LLAVE    = 1'b1;
    FRENO    = 1'b1;

    // Reset overrides a present key.
    step_chk(2, "reset", 4'b0000);
    check_fallos("reset_fallos", 4'd0);

    // Gas start with exact latency: high after E7, not after E6.
    REINICIO = 1'b0;
    SELECTOR = 1'b1;
    step_chk(1, "espera_listo", 4'b0010);
    tick(2);
    BOTON = 1'b1;
    step_chk(6, "gas_e6_not_yet", 4'b0010);
    step_chk(1, "gas_e7_arranque", 4'b1100);
    BOTON = 1'b0;
    tick(8);

    // In ARRANCADO, switch change and a new press are ignored.
    push_exp("gas_hold", 4'b1100);
    SELECTOR = 1'b0;
    press();
    pop_check();
    LLAVE = 1'b0;
    step_chk(1, "gas_llave_off", 4'b0000);
    check_fallos("gas_off_fallos", 4'd0);

    // Short 3-cycle pulses produce no press, with and without brake.
    LLAVE = 1'b1;
    FRENO = 1'b1;
    step_chk(1, "espera2", 4'b0010);
    BOTON = 1'b1;
    tick(3);
    BOTON = 1'b0;
    step_chk(10, "short_pulse_brake", 4'b0010);
    FRENO = 1'b0;
    BOTON = 1'b1;
    tick(3);
    BOTON = 1'b0;
    step_chk(10, "short_pulse_nobrake", 4'b0010);
    check_fallos("short_pulse_fallos", 4'd0);

    // Three presses without brake lead to lockout.
    push_exp("fail1", 4'b0010);
    press();
    pop_check();
    check_fallos("fail1_fallos", 4'd1);
    push_exp("fail2", 4'b0010);
    press();
    pop_check();
    check_fallos("fail2_fallos", 4'd2);
    BOTON = 1'b1;
    step_chk(6, "fail3_e6", 4'b0010);
    step_chk(1, "fail3_lockout", 4'b0001);
    BOTON = 1'b0;
    tick(8);
    check_fallos("fail3_fallos", 4'd3);

    // Lockout ignores a press with brake; key removal clears it.
    FRENO = 1'b1;
    push_exp("lock_ignores_press", 4'b0001);
    press();
    pop_check();
    LLAVE = 1'b0;
    step_chk(1, "lock_llave_off", 4'b0000);
    check_fallos("lock_off_fallos", 4'd0);

    // Electric start; mode stays 0 despite switch change and press.
    LLAVE    = 1'b1;
    SELECTOR = 1'b0;
    step_chk(3, "espera3", 4'b0010);
    BOTON = 1'b1;
    step_chk(7, "elec_start", 4'b1000);
    BOTON = 1'b0;
    tick(8);
    SELECTOR = 1'b1;
    tick(4);
    push_exp("elec_hold", 4'b1000);
    press();
    pop_check();
    LLAVE = 1'b0;
    step_chk(1, "elec_llave_off", 4'b0000);

    // Key removal coincident with the press event wins.
    LLAVE = 1'b1;
    step_chk(1, "espera4", 4'b0010);
    BOTON = 1'b1;
    tick(6);
    LLAVE = 1'b0;
    step_chk(1, "press_vs_llave", 4'b0000);
    step_chk(3, "apagado_hold", 4'b0000);
    BOTON = 1'b0;
    tick(8);

    // Reset in ARRANCADO with the button held across it.
    LLAVE = 1'b1;
    step_chk(1, "espera5", 4'b0010);
    BOTON = 1'b1;
    step_chk(7, "gas_start2", 4'b1100);
    REINICIO = 1'b1;
    step_chk(1, "reset_arrancado", 4'b0000);
    REINICIO = 1'b0;
    step_chk(1, "post_rst_espera", 4'b0010);
    step_chk(5, "post_rst_e6", 4'b0010);
    step_chk(1, "post_rst_e7", 4'b1100);

    // Reset mid-debounce restarts the full debounce interval.
    LLAVE = 1'b0;
    BOTON = 1'b0;
    step_chk(8, "off_again", 4'b0000);
    LLAVE = 1'b1;
    step_chk(1, "espera6", 4'b0010);
    BOTON = 1'b1;
    tick(4);
    REINICIO = 1'b1;
    step_chk(1, "reset_mid_debounce", 4'b0000);
    REINICIO = 1'b0;
    step_chk(1, "mid_rst_espera", 4'b0010);
    step_chk(5, "mid_rst_e6", 4'b0010);
    step_chk(1, "mid_rst_e7", 4'b1100);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
